// File: rtl/iddr_deser_pkg.sv
// iddr_deser_pkg
//   Shared definitions for the multi-channel DDR input deserialiser:
//   - ddr_mode_e      : input-stage mode encoding
//   - ddr_mode_known  : tells whether a DDR_CLK_EDGE string is recognised
//   - ddr_mode_enc    : maps a DDR_CLK_EDGE string to ddr_mode_e
//   - slip_w / cnt_w  : widths of the slip offset and pair counter
package iddr_deser_pkg;

    // DDR_CLK_EDGE strings are compared as fixed-width byte vectors.
    localparam int unsigned MODE_NAME_W = 8 * 24;

    typedef enum logic {
        DDR_MODE_SAME_EDGE           = 1'b0,
        DDR_MODE_SAME_EDGE_PIPELINED = 1'b1
    } ddr_mode_e;

    function automatic logic ddr_mode_known(input logic [MODE_NAME_W-1:0] name);
        return (name == MODE_NAME_W'("SAME_EDGE")) ||
               (name == MODE_NAME_W'("SAME_EDGE_PIPELINED"));
    endfunction

    function automatic ddr_mode_e ddr_mode_enc(input logic [MODE_NAME_W-1:0] name);
        return (name == MODE_NAME_W'("SAME_EDGE_PIPELINED")) ?
               DDR_MODE_SAME_EDGE_PIPELINED : DDR_MODE_SAME_EDGE;
    endfunction

    // Width of SLIP_POS: $clog2(RATIO), never below 1.
    function automatic int unsigned slip_w(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    // Pair counter must hold 0..RATIO/2 (RATIO/2 is the extra-pair state).
    function automatic int unsigned cnt_w(input int unsigned ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio / 2 + 1);
    endfunction

endpackage

// File: rtl/iddr_deser_lane.sv
// iddr_deser_lane
//   One data channel: RATIO+1 sample history shifted by two per enabled
//   cycle, plus the parity mux that picks the RATIO-sample word.
//   Ports:
//     C, RST_N  clock / async active-low reset
//     shift_en  shift the history this cycle
//     d_rise    older sample of the pair (goes to H[1])
//     d_fall    newer sample of the pair (goes to H[0])
//     sel_odd   slip parity; 1 selects H[RATIO..1], 0 selects H[RATIO-1..0]
//     word      word built from the post-shift history, bit 0 oldest
module iddr_deser_lane
    import iddr_deser_pkg::*;
#(
    parameter int unsigned RATIO = 4
) (
    input  logic             C,
    input  logic             RST_N,
    input  logic             shift_en,
    input  logic             d_rise,
    input  logic             d_fall,
    input  logic             sel_odd,
    output logic [RATIO-1:0] word
);

    logic [RATIO:0] hist_q;
    logic [RATIO:0] hist_next;

    always_comb begin
        hist_next = {hist_q[RATIO-2:0], d_rise, d_fall};
    end

    always_ff @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            hist_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_next;
        end
    end

    // The word is taken from hist_next so the register loads on the same
    // edge that shifts in the completing pair.
    always_comb begin
        word = '0;
        for (int unsigned j = 0; j < RATIO; j++) begin
            word[j] = sel_odd ? hist_next[RATIO - j] : hist_next[RATIO - 1 - j];
        end
    end

endmodule

// File: rtl/iddr_deser.sv
// iddr_deser
//   Multi-channel DDR input deserialiser with run-time bitslip.
//   Ports:
//     C         clock, all logic on posedge
//     RST_N     asynchronous active-low reset
//     CE        capture enable; a rise/fall pair is consumed when 1
//     D_RISE    rising-edge sample per channel (older)
//     D_FALL    falling-edge sample per channel (newer)
//     BITSLIP   request to delay word alignment by one sample
//     Q         channel n at Q[n*RATIO +: RATIO], bit 0 oldest sample
//     Q_VALID   one-cycle strobe, Q is new
//     SLIP_POS  current slip offset 0..RATIO-1
module iddr_deser
    import iddr_deser_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned RATIO        = 4,
    parameter              DDR_CLK_EDGE = "SAME_EDGE"
) (
    input  logic                       C,
    input  logic                       RST_N,
    input  logic                       CE,
    input  logic [WIDTH-1:0]           D_RISE,
    input  logic [WIDTH-1:0]           D_FALL,
    input  logic                       BITSLIP,
    output logic [WIDTH*RATIO-1:0]     Q,
    output logic                       Q_VALID,
    output logic [slip_w(RATIO)-1:0]   SLIP_POS
);

    localparam ddr_mode_e   MODE    = ddr_mode_enc(MODE_NAME_W'(DDR_CLK_EDGE));
    localparam int unsigned SLIP_W  = slip_w(RATIO);
    localparam int unsigned CNT_W   = cnt_w(RATIO);
    localparam int unsigned HALF    = RATIO / 2;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  CNT_EXTRA = CNT_W'(HALF);
    localparam logic [SLIP_W-1:0] SLIP_MAX  = SLIP_W'(RATIO - 1);

    generate
        if (!(RATIO >= 2 && RATIO <= 16 && (RATIO % 2) == 0 && WIDTH >= 1 &&
              ddr_mode_known(MODE_NAME_W'(DDR_CLK_EDGE)))) begin : g_bad_param
            $fatal(1, "Attribute Syntax Error: iddr_deser WIDTH=%0d RATIO=%0d DDR_CLK_EDGE=%s",
                   WIDTH, RATIO, DDR_CLK_EDGE);
        end
    endgenerate

    // ---------------------------------------------------------------
    // Optional input register stage (data and enable only)
    // ---------------------------------------------------------------
    logic             ce_c;
    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;

    generate
        if (MODE == DDR_MODE_SAME_EDGE_PIPELINED) begin : g_pipe
            logic             ce_p;
            logic [WIDTH-1:0] rise_p;
            logic [WIDTH-1:0] fall_p;

            always_ff @(posedge C or negedge RST_N) begin
                if (!RST_N) begin
                    ce_p   <= 1'b0;
                    rise_p <= '0;
                    fall_p <= '0;
                end else begin
                    ce_p   <= CE;
                    rise_p <= D_RISE;
                    fall_p <= D_FALL;
                end
            end

            always_comb begin
                ce_c   = ce_p;
                rise_c = rise_p;
                fall_c = fall_p;
            end
        end else begin : g_direct
            always_comb begin
                ce_c   = CE;
                rise_c = D_RISE;
                fall_c = D_FALL;
            end
        end
    endgenerate

    // ---------------------------------------------------------------
    // Per-channel history and word selection
    // ---------------------------------------------------------------
    logic [SLIP_W-1:0]      slip_pos_q;
    logic [WIDTH*RATIO-1:0] word_all;

    for (genvar n = 0; n < WIDTH; n++) begin : g_lane
        iddr_deser_lane #(
            .RATIO (RATIO)
        ) u_lane (
            .C        (C),
            .RST_N    (RST_N),
            .shift_en (ce_c),
            .d_rise   (rise_c[n]),
            .d_fall   (fall_c[n]),
            .sel_odd  (slip_pos_q[0]),
            .word     (word_all[n*RATIO +: RATIO])
        );
    end

    // ---------------------------------------------------------------
    // Pair counter and slip control
    // ---------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              pend_q;
    logic              pend_d;
    logic [SLIP_W-1:0] slip_inc;
    logic              word_done;
    logic              slip_apply;
    logic [WIDTH*RATIO-1:0] q_q;
    logic              q_valid_q;

    always_comb begin
        word_done  = ce_c && (cnt_q == CNT_LAST);
        slip_apply = word_done && pend_q;
        slip_inc   = (slip_pos_q == SLIP_MAX) ? '0 : slip_pos_q + 1'b1;

        // cnt == CNT_EXTRA is the one-pair detour taken after an odd->even
        // slip; it consumes a pair without completing a word, which moves
        // the frame boundary by the second sample of that slip.
        cnt_d = cnt_q;
        if (ce_c) begin
            if (word_done) begin
                cnt_d = (slip_apply && !slip_inc[0]) ? CNT_EXTRA : '0;
            end else if (cnt_q == CNT_EXTRA) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        pend_d = pend_q;
        if (slip_apply) begin
            pend_d = 1'b0;
        end else if (BITSLIP) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge C or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            slip_pos_q <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            q_valid_q <= word_done;
            if (word_done) begin
                q_q <= word_all;
            end
            if (slip_apply) begin
                slip_pos_q <= slip_inc;
            end
        end
    end

    always_comb begin
        Q        = q_q;
        Q_VALID  = q_valid_q;
        SLIP_POS = slip_pos_q;
    end

endmodule

// File: doc/iddr_deser.md
# iddr_deser

Parametrised multi-channel DDR input deserialiser sitting directly behind the per-pin IDDR capture flops of the DDR3 read path. It takes rise/fall sample pairs for WIDTH channels, all in one clock domain, and assembles them into RATIO-sample parallel words per channel. Word alignment is adjustable at run time by a single-sample bitslip. An optional input pipeline stage is selected by mode.

## Interface
Parameters:
- WIDTH, 8: number of data channels (≥1).
- RATIO, 4: samples per output word per channel; even, 2..16.
- DDR_CLK_EDGE, "SAME_EDGE": "SAME_EDGE" or "SAME_EDGE_PIPELINED". The pipelined mode adds one input register stage.

Ports:
- C  in  1  clock; all logic on posedge C.
- RST_N  in  1  asynchronous, active-low reset.
- CE  in  1  capture enable; a pair is consumed only in cycles with CE=1.
- D_RISE  in  WIDTH  rising-edge sample per channel (older of the pair).
- D_FALL  in  WIDTH  falling-edge sample per channel (newer of the pair).
- BITSLIP  in  1  single-cycle request to delay word alignment by one sample.
- Q  out  WIDTH*RATIO  assembled words; channel n occupies Q[n*RATIO +: RATIO], with bit 0 the oldest sample.
- Q_VALID  out  1  one-cycle strobe; Q is new in that cycle.
- SLIP_POS  out  $clog2(RATIO)  current slip offset s, 0..RATIO-1.

## Operation
- Each channel keeps a history H[0..RATIO] of RATIO+1 samples, where H[0] is the newest. On each enabled cycle the history shifts by two: D_RISE goes to H[1] and D_FALL goes to H[0].
- Pair counter cnt runs 0..RATIO/2-1 and advances on enabled cycles. Completing a word means an enabled cycle with cnt==RATIO/2-1. On that edge:
  - Q loads from the post-shift history.
  - Q_VALID is driven 1 for the next cycle.
  - cnt returns to 0.
- Word selection depends on the parity of s:
  - s[0]=0: Q word = H[RATIO-1..0], with H[RATIO-1] at bit 0.
  - s[0]=1: Q word = H[RATIO..1], with H[RATIO] at bit 0.
- BITSLIP handling:
  - If BITSLIP=1 (sampled regardless of CE) and no slip is pending, set the pending flag. BITSLIP while a slip is pending is ignored.
  - A pending slip is applied on the next word-completion edge, after Q has loaded with the old setting. At that edge s ← (s+1) mod RATIO, SLIP_POS updates, and the pending flag clears.
  - If the new s[0]=1: change the selection only.
  - If the new s[0]=0 (odd→even, including the wrap RATIO-1→0): cnt loads RATIO/2 instead of 0. The next word then takes RATIO/2+1 enabled cycles, which drops one pair.
  - Net effect: every slip delays the frame boundary by exactly one sample.
- When CE=0: no shift, cnt holds, and Q_VALID is 0 on the following cycle. Q and SLIP_POS hold.
- Illegal parameter values (RATIO odd, <2 or >16, WIDTH<1, unknown DDR_CLK_EDGE) print an "Attribute Syntax Error" message and $finish at time 0.

## Timing
- Reset: asynchronous on RST_N=0. Q=0, Q_VALID=0, SLIP_POS=0; history, cnt, pending flag and pipeline stage are all 0. Reset applies immediately, including mid-word or with a slip pending, and the pending slip is discarded.
- SAME_EDGE latency: a pair presented at edge k with CE=1 completing a word produces Q/Q_VALID visible after edge k, i.e. in cycle k+1.
- SAME_EDGE_PIPELINED: D_RISE, D_FALL and CE pass through one register stage first, so latency is one cycle more.
- Continuous CE=1: Q_VALID period is RATIO/2 cycles, except the word following an odd→even slip, which takes RATIO/2+1 cycles.
- BITSLIP in the same cycle as a word completion is taken as pending and applies on the next completion, not the current one.
- First word after reset completes after RATIO/2 enabled cycles. With s=0 it contains only new samples.

## Structure
- Package iddr_deser_pkg holds:
  - mode encodings DDR_MODE_SAME_EDGE=0 and DDR_MODE_SAME_EDGE_PIPELINED=1;
  - the string-to-encoding function;
  - the slip-width function (SLIP_W = $clog2(RATIO), minimum 1).
- Sub-module iddr_deser_lane covers one channel: history shift register plus parity mux to a RATIO-bit word. It is generated WIDTH times.
- Top level holds the optional input stage, cnt, slip/pending control, Q and Q_VALID registers.

## Test plan
Unless noted: WIDTH=2, RATIO=4, mode SAME_EDGE.
- Reset: hold RST_N=0 and apply inputs → Q=0, Q_VALID=0, SLIP_POS=0. Assert RST_N mid-word → outputs go to 0 without waiting for C.
- Basic assembly: with CE=1, drive ch0 samples 1,0,1,1 then 0,0,1,0 → Q[3:0]=4'b1101 with Q_VALID after the 2nd pair, then Q[3:0]=4'b0100 two cycles later.
- Bitslip sweep: drive a repeating sample pattern 1,0,0,0 and pulse BITSLIP once per word. Words go 4'b0001 → 4'b0010 (s=1) → 4'b0100 (s=2) → 4'b1000 (s=3) → 4'b0001 (s=0). The Q_VALID gap is 3 cycles after each odd→even slip.
- CE gating: toggle CE 1,0,1,0 → Q_VALID only after the 2nd enabled cycle, and Q holds while CE=0.
- Boundary slips: BITSLIP coincident with Q_VALID, and a second BITSLIP while one is pending → exactly one increment of SLIP_POS, applied at the following word.
- Pipelined mode: repeat the basic assembly with SAME_EDGE_PIPELINED → identical words, each Q_VALID one cycle later.
